// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: round-robin N-to-1 arbiter for 32-bit FWFT source FIFOs.
// Presents a single FWFT interface (FIFO_EMPTY/FIFO_DATA/FIFO_READ) through a
// one-entry registered output stage. Each source may supply at most MAX_BURST
// consecutive words while another source has data waiting.
// Optional per-source word counters are enabled by the macro
// FIFO_READ_ARBITER_WORD_CNT_EN (adds WORD_CNT_CLR input and WORD_CNT output).
module fifo_read_arbiter #(
  parameter int N_SRC     = 2,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic                   BUS_CLK,
  input  logic                   BUS_RST,
  input  logic [N_SRC-1:0]       SRC_EMPTY,
  input  logic [32*N_SRC-1:0]    SRC_DATA,
  output logic [N_SRC-1:0]       SRC_READ,
  input  logic                   FIFO_READ,
  output logic                   FIFO_EMPTY,
  output logic [31:0]            FIFO_DATA,
  output logic [2:0]             GRANT
`ifdef FIFO_READ_ARBITER_WORD_CNT_EN
  ,
  input  logic                   WORD_CNT_CLR,
  output logic [CNT_W*N_SRC-1:0] WORD_CNT
`endif
);

  // Burst counter is wide enough for MAX_BURST up to 256.
  localparam logic [8:0] BURST_LAST = 9'(MAX_BURST - 1);

  logic [2:0]  grant_q, grant_d;
  logic [8:0]  burst_q, burst_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] data_q, data_d;

  logic        load;
  logic        rotate;
  logic        scan_found;
  logic [2:0]  scan_idx;

  // Sources padded to 8 slots so a 3-bit grant can index them directly;
  // unused slots look permanently empty.
  logic [7:0]  empty_pad;
  logic [31:0] data_arr [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < N_SRC) begin : g_real
        assign empty_pad[gi] = SRC_EMPTY[gi];
        assign data_arr[gi]  = SRC_DATA[32*gi +: 32];
      end else begin : g_none
        assign empty_pad[gi] = 1'b1;
        assign data_arr[gi]  = 32'd0;
      end
    end
  endgenerate

  // Output-stage load: granted source has a word and the register is free
  // or being drained this cycle. Held off while reset is asserted.
  always_comb begin
    load = ~BUS_RST & ~empty_pad[grant_q] & (~out_valid_q | FIFO_READ);
  end

  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_read
      assign SRC_READ[gi] = load & (grant_q == 3'(gi));
    end
  endgenerate

  // Round-robin scan: first non-empty source after the current grant.
  // Iterating from the farthest candidate down lets the nearest one win.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = grant_q;
    for (int k = N_SRC - 1; k >= 1; k--) begin
      if (!empty_pad[3'((int'(grant_q) + k) % N_SRC)]) begin
        scan_found = 1'b1;
        scan_idx   = 3'((int'(grant_q) + k) % N_SRC);
      end
    end
  end

  // Grant/burst next state: rotate at burst end or when the granted source
  // runs dry; with no other candidate the grant stays and the burst restarts.
  always_comb begin
    rotate  = (load && (burst_q == BURST_LAST)) || empty_pad[grant_q];
    grant_d = grant_q;
    burst_d = burst_q;
    if (rotate) begin
      burst_d = 9'd0;
      if (scan_found) begin
        grant_d = scan_idx;
      end
    end else if (load) begin
      burst_d = burst_q + 9'd1;
    end
  end

  // Output register next state: occupancy and captured data.
  always_comb begin
    out_valid_d = load | (out_valid_q & ~FIFO_READ);
    data_d      = load ? data_arr[grant_q] : data_q;
  end

  // State registers; reset discards any word held in the output stage.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      grant_q     <= 3'd0;
      burst_q     <= 9'd0;
      out_valid_q <= 1'b0;
      data_q      <= 32'd0;
    end else begin
      grant_q     <= grant_d;
      burst_q     <= burst_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
    end
  end

  assign FIFO_EMPTY = ~out_valid_q;
  assign FIFO_DATA  = data_q;
  assign GRANT      = grant_q;

`ifdef FIFO_READ_ARBITER_WORD_CNT_EN
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Saturating word count; clear wins over a same-cycle read.
      always_comb begin
        cnt_d = cnt_q;
        if (WORD_CNT_CLR) begin
          cnt_d = '0;
        end else if (SRC_READ[gi] && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Counter register.
      always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign WORD_CNT[CNT_W*gi +: CNT_W] = cnt_q;
    end
  endgenerate
`else
  // CNT_W only sizes the optional counters.
  logic cnt_w_unused;
  assign cnt_w_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter: directed scoreboard bench for fifo_read_arbiter
// (N_SRC=2, MAX_BURST=4). Source FIFOs are modelled as queues; expected
// output words are queued as stimulus is driven and popped on consumption.
module tb_fifo_read_arbiter;

  localparam int N = 2;
`ifdef FIFO_READ_ARBITER_WORD_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic          bus_clk = 1'b0;
  logic          bus_rst;
  logic [N-1:0]  src_empty;
  logic [32*N-1:0] src_data;
  logic [N-1:0]  src_read;
  logic          fifo_read;
  logic          fifo_empty;
  logic [31:0]   fifo_data;
  logic [2:0]    grant;
`ifdef FIFO_READ_ARBITER_WORD_CNT_EN
  logic          word_cnt_clr;
  logic [TB_CNT_W*N-1:0] word_cnt;
`endif

  fifo_read_arbiter #(
    .N_SRC(N),
    .MAX_BURST(4),
    .CNT_W(TB_CNT_W)
  ) dut (
    .BUS_CLK(bus_clk),
    .BUS_RST(bus_rst),
    .SRC_EMPTY(src_empty),
    .SRC_DATA(src_data),
    .SRC_READ(src_read),
    .FIFO_READ(fifo_read),
    .FIFO_EMPTY(fifo_empty),
    .FIFO_DATA(fifo_data),
    .GRANT(grant)
`ifdef FIFO_READ_ARBITER_WORD_CNT_EN
    ,
    .WORD_CNT_CLR(word_cnt_clr),
    .WORD_CNT(word_cnt)
`endif
  );

  always #5 bus_clk = ~bus_clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [31:0] srcq0 [$];
  logic [31:0] srcq1 [$];
  logic [31:0] exp_q [$];

  logic        pend_valid = 1'b0;
  logic [31:0] pend_word  = 32'd0;
  int rd_cnt   [2];
  int first_rd [2];
  int last_rd  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input int tst, input int s, input int k);
    return {8'(tst), 8'(s), 16'(k)};
  endfunction

  function automatic int qsize(input int s);
    return (s == 0) ? srcq0.size() : srcq1.size();
  endfunction

  function automatic logic [31:0] qhead(input int s);
    return (s == 0) ? srcq0[0] : srcq1[0];
  endfunction

  function automatic void qpop(input int s);
    if (s == 0) void'(srcq0.pop_front());
    else        void'(srcq1.pop_front());
  endfunction

  function automatic void drive_src();
    src_empty[0]    = (srcq0.size() == 0);
    src_empty[1]    = (srcq1.size() == 0);
    src_data[31:0]  = (srcq0.size() != 0) ? srcq0[0] : 32'd0;
    src_data[63:32] = (srcq1.size() != 0) ? srcq1[0] : 32'd0;
  endfunction

  function automatic void push_src(input int tst, input int s, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      if (s == 0) srcq0.push_back(mkw(tst, s, k));
      else        srcq1.push_back(mkw(tst, s, k));
    end
    drive_src();
  endfunction

  function automatic void push_exp(input int tst, input int s, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) exp_q.push_back(mkw(tst, s, k));
  endfunction

  function automatic void clr_stats();
    for (int i = 0; i < 2; i++) begin
      rd_cnt[i]   = 0;
      first_rd[i] = -1;
      last_rd[i]  = -1;
    end
  endfunction

  // One clock: observe at the falling edge, update the source model after
  // the rising edge.
  task automatic cycle();
    logic [1:0]  rd;
    logic [31:0] exp_w;
    @(negedge bus_clk);
    cyc++;
    chk("src_read_onehot0", 32'($onehot0(src_read)), 32'd1);
    if (pend_valid) begin
      chk("read_to_data_latency", fifo_data, pend_word);
      chk("data_valid_after_read", 32'(fifo_empty), 32'd0);
    end
    pend_valid = 1'b0;
    rd = src_read;
    for (int i = 0; i < 2; i++) begin
      if (rd[i]) begin
        chk("read_nonempty_src", 32'(qsize(i) != 0), 32'd1);
        rd_cnt[i]++;
        if (first_rd[i] < 0) first_rd[i] = cyc;
        last_rd[i] = cyc;
        if (qsize(i) != 0) begin
          pend_valid = 1'b1;
          pend_word  = qhead(i);
        end
      end
    end
    if (!fifo_empty && fifo_read) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_word: observed=%h expected=none", fifo_data);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        $display("xfer cyc=%0d grant=%0d data=%h expect=%h", cyc, grant, fifo_data, exp_w);
        chk("output_word", fifo_data, exp_w);
      end
    end
    @(posedge bus_clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rd[i] && qsize(i) != 0) qpop(i);
    end
    drive_src();
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int b;
    b = 0;
    while (exp_q.size() > 0 && b < budget) begin
      cycle();
      b++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_rst   = 1'b1;
    fifo_read = 1'b0;
`ifdef FIFO_READ_ARBITER_WORD_CNT_EN
    word_cnt_clr = 1'b0;
`endif
    drive_src();
    clr_stats();

    // Reset state
    repeat (2) @(negedge bus_clk);
    chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("rst_src_read", 32'(src_read), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_fifo_data", fifo_data, 32'd0);
`ifdef FIFO_READ_ARBITER_WORD_CNT_EN
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
`endif
    @(posedge bus_clk);
    #1 bus_rst = 1'b0;
    #1;

    // Single source streaming, other source empty
    clr_stats();
    fifo_read = 1'b1;
    push_src(1, 0, 0, 5);
    push_exp(1, 0, 0, 5);
    drain("t1_drain", 30);
    chk("t1_src0_reads", 32'(rd_cnt[0]), 32'd5);
    chk("t1_src0_consecutive", 32'(last_rd[0] - first_rd[0] + 1), 32'd5);
    chk("t1_src1_reads", 32'(rd_cnt[1]), 32'd0);
    chk("t1_empty_after", 32'(fifo_empty), 32'd1);
    chk("t1_grant_after", 32'(grant), 32'd0);

    // Burst limit 4 with both sources busy
    clr_stats();
    push_src(2, 0, 0, 10);
    push_src(2, 1, 0, 10);
    push_exp(2, 0, 0, 4);
    push_exp(2, 1, 0, 4);
    push_exp(2, 0, 4, 4);
    push_exp(2, 1, 4, 4);
    push_exp(2, 0, 8, 2);
    push_exp(2, 1, 8, 2);
    drain("t2_drain", 60);
    chk("t2_src0_reads", 32'(rd_cnt[0]), 32'd10);
    chk("t2_src1_reads", 32'(rd_cnt[1]), 32'd10);
    // 20 reads, one bubble where source 0 ran dry mid-burst
    chk("t2_read_span", 32'(last_rd[1] - first_rd[0] + 1), 32'd21);
    chk("t2_grant_after", 32'(grant), 32'd1);

    // Backpressure
    clr_stats();
    fifo_read = 1'b0;
    push_src(3, 0, 0, 3);
    push_exp(3, 0, 0, 3);
    cycle();
    chk("t3_rotate_bubble_reads", 32'(rd_cnt[0]), 32'd0);
    chk("t3_grant_rotated", 32'(grant), 32'd0);
    cycle();
    chk("t3_first_load", 32'(rd_cnt[0]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t3_hold_data", fifo_data, mkw(3, 0, 0));
      chk("t3_hold_no_read", 32'(src_read), 32'd0);
      chk("t3_hold_valid", 32'(fifo_empty), 32'd0);
    end
    chk("t3_reads_during_hold", 32'(rd_cnt[0]), 32'd1);
    fifo_read = 1'b1;
    cycle();
    fifo_read = 1'b0;
    chk("t3_one_pulse_reads", 32'(rd_cnt[0]), 32'd2);
    chk("t3_one_pulse_data", fifo_data, mkw(3, 0, 1));
    cycle();
    cycle();
    chk("t3_no_extra_reads", 32'(rd_cnt[0]), 32'd2);
    fifo_read = 1'b1;
    drain("t3_drain", 20);

    // Read strobe while output stage is empty
    clr_stats();
    cycle();
    fifo_read = 1'b0;
    cycle();
    fifo_read = 1'b1;
    cycle();
    cycle();
    fifo_read = 1'b0;
    cycle();
    chk("t4_no_src0_read", 32'(rd_cnt[0]), 32'd0);
    chk("t4_no_src1_read", 32'(rd_cnt[1]), 32'd0);
    chk("t4_grant", 32'(grant), 32'd0);
    chk("t4_empty", 32'(fifo_empty), 32'd1);

    // Asynchronous reset mid-burst (count=2)
    clr_stats();
    fifo_read = 1'b1;
    push_src(5, 0, 0, 8);
    push_exp(5, 0, 0, 8);
    cycle();
    cycle();
    chk("t5_pre_rst_data", fifo_data, mkw(5, 0, 1));
    #1 bus_rst = 1'b1;
    #1;
    chk("t5_rst_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("t5_rst_src_read", 32'(src_read), 32'd0);
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_fifo_data", fifo_data, 32'd0);
    // The word held in the output register is discarded by reset
    void'(exp_q.pop_front());
    pend_valid = 1'b0;
    @(negedge bus_clk);
    chk("t5_rst_hold_src_read", 32'(src_read), 32'd0);
    @(posedge bus_clk);
    #1 bus_rst = 1'b0;
    #1;
    chk("t5_post_rst_empty", 32'(fifo_empty), 32'd1);
    chk("t5_post_rst_grant", 32'(grant), 32'd0);
    drain("t5_drain", 30);
    chk("t5_src0_reads", 32'(rd_cnt[0]), 32'd8);

`ifdef FIFO_READ_ARBITER_WORD_CNT_EN
    // Saturating word counters and clear
    chk("t6_cnt0_after_rst", 32'(word_cnt[3:0]), 32'd6);
    clr_stats();
    push_src(6, 1, 0, 20);
    push_exp(6, 1, 0, 20);
    drain("t6_drain", 60);
    chk("t6_cnt1_saturated", 32'(word_cnt[7:4]), 32'd15);
    chk("t6_cnt0_unchanged", 32'(word_cnt[3:0]), 32'd6);
    push_src(6, 1, 20, 1);
    push_exp(6, 1, 20, 1);
    word_cnt_clr = 1'b1;
    cycle();
    word_cnt_clr = 1'b0;
    chk("t6_read_with_clr", 32'(rd_cnt[1]), 32'd21);
    chk("t6_cnt_cleared", 32'(word_cnt), 32'd0);
    drain("t6_drain_b", 10);
    push_src(6, 1, 21, 1);
    push_exp(6, 1, 21, 1);
    drain("t6_drain_c", 10);
    chk("t6_cnt1_restart", 32'(word_cnt[7:4]), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
